// File: rtl/common.sv
// Shared types for the cacheline memory interface between caches and memory.
// Physical pointers, line payloads and the outstanding-read record live here.
package common;

    localparam int PADDR_W    = 32;
    localparam int LINE_BYTES = 16;
    localparam int LINE_OFF   = $clog2(LINE_BYTES);
    localparam int CL_W       = LINE_BYTES * 8;

    localparam int MEM_LINES_DEF   = 4096;
    localparam int MEM_LATENCY_DEF = 5;
    localparam int QUEUE_DEPTH_DEF = 8;

    // Due-time stamp width; wide enough that in-flight stamps never alias.
    localparam int CNT_W = $clog2(QUEUE_DEPTH_DEF + MEM_LATENCY_DEF) + 1;

    typedef logic [PADDR_W-1:0] pptr_t;
    typedef logic [CL_W-1:0]    cacheline_t;

    typedef struct packed {
        pptr_t            addr;
        logic [CNT_W-1:0] due;
    } memreq_t;

    function automatic pptr_t line_align(input pptr_t a);
        line_align = a & ~pptr_t'(LINE_BYTES - 1);
    endfunction

    function automatic bit is_pow2(input int v);
        is_pow2 = (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/main_memory_resp_fifo.sv
// Circular buffer of outstanding reads, in acceptance order.
// Push and pop may coincide; a push while full is only taken with a pop.
module mem_resp_fifo
    import common::*;
#(
    parameter int DEPTH = QUEUE_DEPTH_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  memreq_t                i_data,
    input  logic                   i_pop,
    output memreq_t                o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    memreq_t          r_buf [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;

    logic w_pop;
    logic w_push;

    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_buf[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_buf[r_rptr];
    assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/main_memory.sv
// Fixed-latency behavioural line memory answering cache read/write requests.
// MAIN_MEMORY_PRELOAD_EN: storage is kept over rst.
module main_memory
    import common::*;
#(
    parameter int MEM_LINES   = MEM_LINES_DEF,
    parameter int MEM_LATENCY = MEM_LATENCY_DEF,
    parameter int QUEUE_DEPTH = QUEUE_DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mem_req_ren,
    input  pptr_t                        mem_req_raddr,
    input  logic                         mem_req_wen,
    input  pptr_t                        mem_req_waddr,
    input  cacheline_t                   mem_req_wcacheline,
    output logic                         mem_rec_en,
    output pptr_t                        mem_rec_addr,
    output cacheline_t                   mem_rec_cacheline,
    output logic [$clog2(QUEUE_DEPTH):0] mem_pending,
    output logic                         mem_overflow
);

    localparam int IDX_W     = $clog2(MEM_LINES);
    localparam int CNT_W_MIN = $clog2(QUEUE_DEPTH + MEM_LATENCY) + 1;

    if (QUEUE_DEPTH < MEM_LATENCY) begin : g_chk_depth
        $error("main_memory: QUEUE_DEPTH must be >= MEM_LATENCY");
    end
    if (!is_pow2(MEM_LINES)) begin : g_chk_lines
        $error("main_memory: MEM_LINES must be a power of 2");
    end
    if (!is_pow2(QUEUE_DEPTH)) begin : g_chk_qpow
        $error("main_memory: QUEUE_DEPTH must be a power of 2");
    end
    if (MEM_LATENCY < 1) begin : g_chk_lat
        $error("main_memory: MEM_LATENCY must be >= 1");
    end
    if (CNT_W_MIN > CNT_W) begin : g_chk_cnt
        $error("main_memory: due stamp too narrow for this depth/latency");
    end

    cacheline_t r_mem [MEM_LINES];

    logic [CNT_W-1:0] r_cnt;
    logic             r_rec_en;
    pptr_t            r_rec_addr;
    cacheline_t       r_rec_line;
    logic             r_overflow;

    memreq_t                      w_req;
    memreq_t                      w_head;
    logic                         w_full;
    logic                         w_empty;
    logic                         w_pop;
    logic                         w_push;
    logic                         w_drop;
    logic [IDX_W-1:0]             w_widx;
    logic [IDX_W-1:0]             w_hidx;
    logic [$clog2(QUEUE_DEPTH):0] w_count;
    logic                         w_unused_waddr;

    assign w_widx = mem_req_waddr[LINE_OFF +: IDX_W];
    assign w_hidx = w_head.addr[LINE_OFF +: IDX_W];

    // Offset and aliasing bits of the write address select nothing.
    assign w_unused_waddr = ^mem_req_waddr;

    assign w_req.addr = line_align(mem_req_raddr);
    assign w_req.due  = r_cnt + CNT_W'(MEM_LATENCY);

    // Fixed latency keeps due stamps ordered, so only the head can be due.
    assign w_pop  = !w_empty && (w_head.due == r_cnt);
    assign w_push = mem_req_ren && (!w_full || w_pop);
    assign w_drop = mem_req_ren && w_full && !w_pop;

    mem_resp_fifo #(
        .DEPTH   (QUEUE_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_push),
        .i_data  (w_req),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

`ifdef MAIN_MEMORY_PRELOAD_EN
    always_ff @(posedge clk) begin
        if (mem_req_wen) begin
            r_mem[w_widx] <= mem_req_wcacheline;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_LINES; i++) begin
                r_mem[i] <= '0;
            end
        end else if (mem_req_wen) begin
            r_mem[w_widx] <= mem_req_wcacheline;
        end
    end
`endif

    // Data is read at pop time, so a same-edge write is not observed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_rec_en   <= 1'b0;
            r_rec_addr <= '0;
            r_rec_line <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_cnt    <= r_cnt + CNT_W'(1);
            r_rec_en <= w_pop;
            if (w_pop) begin
                r_rec_addr <= w_head.addr;
                r_rec_line <= r_mem[w_hidx];
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign mem_rec_en        = r_rec_en;
    assign mem_rec_addr      = r_rec_addr;
    assign mem_rec_cacheline = r_rec_line;
    assign mem_pending       = w_count;
    assign mem_overflow      = r_overflow;

endmodule
